// File: rtl/hr_dq_tx.sv
// hr_dq_tx: transmit-side DDR data path for the HyperRAM controller.
// Write words with byte masks are buffered in a 2-entry FIFO. After a
// programmable latency countdown they are driven as registered rising/falling
// byte pairs plus RWDS mask bits toward the ODDR/OBUFT pad primitives.
// Optional feature macro: HR_TX_UNDERRUN_EN enables the sticky underrun flag.
// Without it the masked filler cycles still happen; only the flag is removed.
module hr_dq_tx #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LAT_W-1:0] lat_cycles,
    input  logic [15:0]      wr_d,
    input  logic [1:0]       wr_m,
    input  logic             wr_last,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       dq_ris,
    output logic [7:0]       dq_fal,
    output logic             dq_oe,
    output logic             rwds_ris,
    output logic             rwds_fal,
    output logic             rwds_oe,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    typedef enum logic [1:0] {
        IDLE,
        LATENCY,
        DATA,
        TAIL
    } state_t;

    // The state names what the output registers are currently showing:
    // DATA means a data (or masked filler) word is on the pins right now.
    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic             last_out;

    logic [15:0]      fifo_d    [2];
    logic [1:0]       fifo_m    [2];
    logic             fifo_last [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;

    logic             push;
    logic             pop;
    logic             emit;
    logic             start_ok;
    logic             fifo_empty;

    // No bypass path: ready depends only on the stored count, and stays low in reset.
    assign wr_ready   = reset_n & (count < 2'd2);
    assign push       = wr_valid & wr_ready;
    assign start_ok   = (state == IDLE) & start;
    assign fifo_empty = (count == 2'd0);

    // An emit edge loads the next output word; the first one coincides with
    // leaving the countdown so the first data cycle lands N+1 cycles after start.
    always_comb begin
        emit = 1'b0;
        if (start_ok && (lat_cycles == '0)) begin
            emit = 1'b1;
        end else if ((state == LATENCY) && (lat_cnt == LAT_W'(1))) begin
            emit = 1'b1;
        end else if ((state == DATA) && !last_out) begin
            emit = 1'b1;
        end
    end

    assign pop = emit & ~fifo_empty;

    // FIFO payload storage; contents need no reset since the count gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d[wr_ptr]    <= wr_d;
            fifo_m[wr_ptr]    <= wr_m;
            fifo_last[wr_ptr] <= wr_last;
        end
    end

    // FIFO pointers and occupancy; reset discards anything buffered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Burst sequencer with registered pad outputs; an emit overrides the per-state step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            last_out <= 1'b0;
            dq_ris   <= 8'h00;
            dq_fal   <= 8'h00;
            dq_oe    <= 1'b0;
            rwds_ris <= 1'b0;
            rwds_fal <= 1'b0;
            rwds_oe  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        last_out <= 1'b0;
                        state    <= LATENCY;
                        lat_cnt  <= lat_cycles;
                    end
                end
                LATENCY: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
                DATA: begin
                    if (last_out) begin
                        state    <= TAIL;
                        last_out <= 1'b0;
                        dq_ris   <= 8'h00;
                        dq_fal   <= 8'h00;
                        rwds_ris <= 1'b0;
                        rwds_fal <= 1'b0;
                        dq_oe    <= 1'b0;
                        rwds_oe  <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                TAIL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (emit) begin
                state   <= DATA;
                dq_oe   <= 1'b1;
                rwds_oe <= 1'b1;
                if (!fifo_empty) begin
                    dq_ris   <= fifo_d[rd_ptr][15:8];
                    dq_fal   <= fifo_d[rd_ptr][7:0];
                    rwds_ris <= fifo_m[rd_ptr][1];
                    rwds_fal <= fifo_m[rd_ptr][0];
                    last_out <= fifo_last[rd_ptr];
                end else begin
                    dq_ris   <= 8'h00;
                    dq_fal   <= 8'h00;
                    rwds_ris <= 1'b1;
                    rwds_fal <= 1'b1;
                    last_out <= 1'b0;
                end
            end
        end
    end

`ifdef HR_TX_UNDERRUN_EN
    // Sticky flag: set by any masked filler cycle, cleared when a new burst starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
        end else if (emit && fifo_empty) begin
            underrun <= 1'b1;
        end else if (start_ok) begin
            underrun <= 1'b0;
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_hr_dq_tx.sv
// tb_hr_dq_tx: scoreboard bench for hr_dq_tx. A transaction-level reference
// model predicts every output cycle into a queue; a monitor compares each
// cycle the DUT presents data or done.
module tb_hr_dq_tx;

    localparam int LAT_W = 4;
`ifdef HR_TX_UNDERRUN_EN
    localparam bit UNDER_EN = 1'b1;
`else
    localparam bit UNDER_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             start = 1'b0;
    logic [LAT_W-1:0] lat_cycles = '0;
    logic [15:0]      wr_d = 16'h0000;
    logic [1:0]       wr_m = 2'b00;
    logic             wr_last = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [7:0]       dq_ris;
    logic [7:0]       dq_fal;
    logic             dq_oe;
    logic             rwds_ris;
    logic             rwds_fal;
    logic             rwds_oe;
    logic             busy;
    logic             done;
    logic             underrun;

    hr_dq_tx #(.LAT_W(LAT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .lat_cycles(lat_cycles),
        .wr_d(wr_d), .wr_m(wr_m), .wr_last(wr_last), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .dq_ris(dq_ris), .dq_fal(dq_fal), .dq_oe(dq_oe),
        .rwds_ris(rwds_ris), .rwds_fal(rwds_fal), .rwds_oe(rwds_oe),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  m;
        logic        last;
    } word_t;

    typedef struct packed {
        logic [7:0] ris;
        logic [7:0] fal;
        logic       rr;
        logic       rf;
        logic       dn;
    } obs_t;

    int     nTests = 0;
    int     nFails = 0;

    // Reference model state: buffered words, predicted outputs, burst phase.
    word_t  mq[$];
    obs_t   expQ[$];
    int     phase = 0;        // 0 idle, 1 burst running, 2 done showing
    int     edgeNo = 0;
    int     firstEmit = 0;
    bit     lastSeen = 1'b0;
    bit     mUnder = 1'b0;
    bit     mOutNow = 1'b0;
    bit     pushOk;
    word_t  mw;
    obs_t   mo;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst emits one word per cycle from start+N until a
    // word marked last has gone out, then one done cycle, then idle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            expQ.delete();
            phase    = 0;
            lastSeen = 1'b0;
            mUnder   = 1'b0;
            mOutNow  = 1'b0;
        end else begin
            edgeNo++;
            mOutNow = 1'b0;
            pushOk  = wr_valid && (mq.size() < 2);
            if (phase == 2) begin
                phase = 0;
            end else if (phase == 1 && lastSeen) begin
                mo = '{ris: 8'h00, fal: 8'h00, rr: 1'b0, rf: 1'b0, dn: 1'b1};
                expQ.push_back(mo);
                mOutNow = 1'b1;
                phase = 2;
            end else begin
                if (phase == 0 && start) begin
                    phase     = 1;
                    firstEmit = edgeNo + int'(lat_cycles);
                    lastSeen  = 1'b0;
                    mUnder    = 1'b0;
                end
                if (phase == 1 && edgeNo >= firstEmit) begin
                    if (mq.size() > 0) begin
                        mw = mq.pop_front();
                        mo = '{ris: mw.d[15:8], fal: mw.d[7:0], rr: mw.m[1], rf: mw.m[0], dn: 1'b0};
                        lastSeen = mw.last;
                    end else begin
                        mo = '{ris: 8'h00, fal: 8'h00, rr: 1'b1, rf: 1'b1, dn: 1'b0};
                        mUnder = 1'b1;
                    end
                    expQ.push_back(mo);
                    mOutNow = 1'b1;
                end
            end
            if (pushOk) begin
                mw = '{d: wr_d, m: wr_m, last: wr_last};
                mq.push_back(mw);
            end
        end
    end

    // Monitor: every cycle check handshake/status, and pop the scoreboard when the DUT presents output.
    always @(negedge clk) begin
        obs_t e;
        if (reset_n) begin
            checkOutput("wr_ready", 32'(wr_ready), 32'(mq.size() < 2));
            checkOutput("busy", 32'(busy), 32'(phase != 0));
            checkOutput("underrun", 32'(underrun), 32'(UNDER_EN & mUnder));
            checkOutput("rwds_oe_vs_dq_oe", 32'(rwds_oe), 32'(dq_oe));
            checkOutput("output_timing", 32'(dq_oe | done), 32'(mOutNow));
            if (dq_oe || done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'(1), 32'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("dq_rwds_done", 32'({dq_ris, dq_fal, rwds_ris, rwds_fal, done}), 32'(e));
                    checkOutput("dq_oe", 32'(dq_oe), 32'(!e.dn));
                end
            end else begin
                checkOutput("quiet_outputs", 32'({dq_ris, dq_fal, rwds_ris, rwds_fal}), 32'(0));
            end
        end
    end

    // Offer one word and hold it until accepted; called and returns at a negedge.
    task automatic applyStimulus(input word_t w);
        int  guard;
        bit  rdy;
        guard = 0;
        wr_d     = w.d;
        wr_m     = w.m;
        wr_last  = w.last;
        wr_valid = 1'b1;
        forever begin
            rdy = wr_ready;
            @(negedge clk);
            if (!reset_n) begin
                wr_valid = 1'b0;
                return;
            end
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                checkOutput("word_accept_timeout", 32'(0), 32'(1));
                break;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic pulseStart(input int lat);
        start      = 1'b1;
        lat_cycles = LAT_W'(lat);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitIdle(input int budget);
        int left;
        left = budget;
        while (!(phase == 0 && expQ.size() == 0 && mq.size() == 0)) begin
            @(negedge clk);
            left--;
            if (left <= 0) begin
                checkOutput("burst_finish_timeout", 32'(phase), 32'(0));
                return;
            end
        end
        @(negedge clk);
    endtask

    function automatic word_t mk(input logic [15:0] d, input logic [1:0] m, input logic last);
        word_t w;
        w = '{d: d, m: m, last: last};
        return w;
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int lat;
        int pre;
        word_t words[$];

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        checkOutput("reset_wr_ready", 32'(wr_ready), 32'(0));
        checkOutput("reset_outputs",
                    32'({dq_ris, dq_fal, dq_oe, rwds_ris, rwds_fal, rwds_oe, busy, done, underrun}), 32'(0));
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        checkOutput("release_wr_ready", 32'(wr_ready), 32'(1));
        checkOutput("release_outputs",
                    32'({dq_ris, dq_fal, dq_oe, rwds_ris, rwds_fal, rwds_oe, busy, done, underrun}), 32'(0));
        @(negedge clk);

        // Two preloaded words, latency 3
        applyStimulus(mk(16'hA1B2, 2'b00, 1'b0));
        applyStimulus(mk(16'hC3D4, 2'b10, 1'b1));
        pulseStart(3);
        waitIdle(100);

        // Zero latency, single word
        applyStimulus(mk(16'h1234, 2'b00, 1'b1));
        pulseStart(0);
        waitIdle(100);

        // Empty FIFO at start, words arrive two cycles late
        fork
            pulseStart(0);
            begin
                idleCycles(2);
                applyStimulus(mk(16'h1111, 2'b00, 1'b0));
                applyStimulus(mk(16'h2222, 2'b01, 1'b0));
                applyStimulus(mk(16'h3333, 2'b00, 1'b1));
            end
        join
        waitIdle(100);
        idleCycles(2);

        // FIFO full with a third word held, and a start pulse during DATA
        applyStimulus(mk(16'h4455, 2'b00, 1'b0));
        applyStimulus(mk(16'h6677, 2'b11, 1'b0));
        fork
            applyStimulus(mk(16'h8899, 2'b01, 1'b1));
            begin
                pulseStart(1);
                idleCycles(1);
                pulseStart(5);
            end
        join
        waitIdle(100);

        // Reset in the middle of a 4-word burst
        fork
            pulseStart(1);
            begin
                applyStimulus(mk(16'hDEAD, 2'b00, 1'b0));
                applyStimulus(mk(16'hBEEF, 2'b00, 1'b0));
                applyStimulus(mk(16'hCAFE, 2'b00, 1'b0));
                applyStimulus(mk(16'hF00D, 2'b00, 1'b1));
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                checkOutput("midburst_dq_oe_before", 32'(dq_oe), 32'(1));
                reset_n = 1'b0;
                #1;
                checkOutput("midburst_oe_after_reset", 32'({dq_oe, rwds_oe}), 32'(0));
                repeat (2) @(posedge clk);
                #2 reset_n = 1'b1;
                @(negedge clk);
            end
        join
        wr_valid = 1'b0;
        @(negedge clk);
        applyStimulus(mk(16'h5A5A, 2'b01, 1'b1));
        pulseStart(2);
        waitIdle(100);

        // Randomized bursts: random lengths, latencies, preload depth and supply gaps
        for (int b = 0; b < 16; b++) begin
            n   = int'($urandom_range(1, 5));
            lat = int'($urandom_range(0, 4));
            pre = int'($urandom_range(0, (n < 2) ? n : 2));
            words.delete();
            for (int i = 0; i < n; i++) begin
                words.push_back(mk(16'($urandom), 2'($urandom_range(0, 3)), (i == n - 1)));
            end
            for (int i = 0; i < pre; i++) begin
                applyStimulus(words[i]);
            end
            fork
                pulseStart(lat);
                begin
                    for (int i = pre; i < n; i++) begin
                        idleCycles(int'($urandom_range(0, 2)));
                        applyStimulus(words[i]);
                    end
                end
            join
            waitIdle(200);
            idleCycles(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule

// File: doc/hr_dq_tx.md
# hr_dq_tx

Transmit-side DDR data path for the HyperRAM controller, the write-direction counterpart of the IDDR capture path. It accepts 16-bit write words with per-byte masks over a valid/ready handshake and buffers them in a 2-entry FIFO. After a programmable latency countdown it drives registered rising/falling-edge byte pairs and RWDS mask bits to the ODDR/OBUFT output primitives. It sits between the controller's burst sequencer and the pad-level DDR output flops.

## Interface
- LAT_W, 4, width of latency count input
- clk  in  1  controller clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  burst start pulse; sampled only in IDLE
- lat_cycles  in  LAT_W  clocks from start acceptance to first data cycle, minus one; sampled with start
- wr_d  in  16  write word; [15:8] sent on rising edge, [7:0] on falling edge
- wr_m  in  2  byte mask, 1 = masked; [1] pairs with wr_d[15:8]
- wr_last  in  1  marks final word of burst
- wr_valid  in  1  word offered
- wr_ready  out  1  word accepted when valid & ready
- dq_ris / dq_fal  out  8 each  DQ bytes for ODDR D1/D2
- dq_oe  out  1  DQ output enable
- rwds_ris / rwds_fal  out  1 each  RWDS mask bits for ODDR D1/D2
- rwds_oe  out  1  RWDS output enable
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- underrun  out  1  sticky FIFO-empty-during-DATA flag

## Operation
- FIFO: 2 entries of {wr_d, wr_m, wr_last}.
  - wr_ready = (count < 2); no bypass, so a push is refused when full even if a pop occurs in the same cycle.
  - Pushes are accepted in any state, which allows preloading during IDLE and LATENCY.
- FSM states: IDLE, LATENCY, DATA, TAIL.
  - IDLE: start=1 → LATENCY with counter = lat_cycles; if lat_cycles = 0, go directly to DATA. start is ignored outside IDLE.
  - LATENCY: counter decrements each cycle; counter = 1 → DATA.
  - DATA, FIFO non-empty: pop one word per cycle and drive dq_ris = d[15:8], dq_fal = d[7:0], rwds_ris = m[1], rwds_fal = m[0]. A popped word with last = 1 → TAIL.
  - DATA, FIFO empty: drive dq = 0x00/0x00, rwds_ris = rwds_fal = 1 (both bytes masked, memory contents preserved) and set underrun. The FSM stays in DATA, so the burst stretches by one masked cycle.
  - TAIL: dq_oe = rwds_oe = 0, done = 1 → IDLE.
- dq_oe and rwds_oe are high exactly during DATA output cycles.
- busy is high from the LATENCY/DATA entry through the done cycle inclusive.
- underrun clears when start is accepted.

## Timing
- All outputs are registered except wr_ready, which is combinational from the FIFO count.
- Reset (reset_n low, async):
  - state IDLE, FIFO empty.
  - All data and control outputs 0, including dq_*, rwds_*, both OEs, busy, done, underrun.
  - wr_ready = 0 while reset_n is low; 1 from the first cycle after release.
- start sampled at edge T with lat_cycles = N:
  - busy = 1 from cycle T+1.
  - First data output cycle is T+1+N, for N = 0 as well.
- K words with no underrun:
  - K consecutive output cycles with dq_oe = 1.
  - done = 1 in the cycle immediately after the last data cycle.
  - busy drops in the following cycle.
- Next start is accepted in the cycle busy is 0 (at earliest T_done+1).
- Reset asserted mid-burst: OEs drop immediately (async) and FIFO contents are discarded.

## Configuration
- HR_TX_UNDERRUN_EN defined:
  - Underrun insertion and the sticky underrun output behave as above.
- Undefined:
  - The underrun port is tied 0.
  - An empty FIFO in DATA still drives masked words, since that behaviour is mandatory for memory safety. Only the flag logic is removed.

## Test plan
- Reset release with FIFO empty → wr_ready = 1, all outputs 0, state IDLE.
- Preload 0xA1B2/m=00 and 0xC3D4/m=10/last, then start with lat_cycles = 3 → data cycles at T+4 and T+5:
  - dq_ris/dq_fal = A1/B2, then C3/D4.
  - rwds = 0/0, then 1/0.
  - done at T+6.
- lat_cycles = 0, single word 0x1234/last preloaded → data at T+1, done at T+2, busy for exactly 2 cycles.
- Start with FIFO empty, then supply 3 words (last on the third) two cycles late → masked cycles (dq = 0, rwds = 1/1) precede the 3 data cycles; underrun = 1 until next start.
- FIFO full plus 3rd word offered → wr_ready = 0 and the word is held unchanged on wr_d until accepted; start pulsed during DATA is ignored.
- reset_n asserted in the middle of a 4-word burst → dq_oe = rwds_oe = 0 asynchronously; after release, a new 1-word burst completes normally.
